led_pulse_scheduler: RTL and testbench
======================================

LED_PULSE_SCHEDULER -- requirements
Module: led_pulse_scheduler

Interface
REQ-001 Parameter PERIOD, default 500000: PWM frame length in clk cycles; legal range 2..2^24-1.
REQ-002 Parameter BLINK_FRAMES, default 50: frames per blink half-period; minimum 1.
REQ-003 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port cmd_valid, input, 1: command present.
REQ-006 Port cmd_ready, output, 1: scheduler can accept a command.
REQ-007 Port cmd_chan, input, 2: target channel 0..3.
REQ-008 Port cmd_mode, input, 2: 0 OFF, 1 ON, 2 BREATHE, 3 BLINK.
REQ-009 Port cmd_step, input, 24: breathe duty increment per frame.
REQ-010 Port led, output, 4: registered per-channel LED drive.
REQ-011 Port frame_tick, output, 1: registered; high for one cycle when the shared counter wraps.

Function
REQ-012 One shared 24-bit counter cnt SHALL count 0..PERIOD-1 and wrap to 0; frame_tick SHALL be high in the cycle cnt==0 after a wrap.
REQ-013 Each channel SHALL hold mode, step, duty (24-bit, 0..PERIOD), dir (0 = up), blink counter and blink phase.
REQ-014 OFF: led[n]=0. ON: led[n]=1.
REQ-015 BREATHE: led[n] SHALL be 1 when cnt < duty, else 0; duty 0 gives 0% and duty PERIOD gives 100%.
REQ-016 BREATHE duty update, once per wrap: if dir up and duty+step >= PERIOD, set duty=PERIOD and dir=down; else add step.
REQ-017 BREATHE duty update, dir down: if duty <= step, set duty=0 and dir=up; else subtract step.
REQ-018 BREATHE arithmetic SHALL use at least 25 bits so duty+step cannot overflow; step=0 holds duty constant.
REQ-019 BLINK: led[n]=phase; the blink counter increments per wrap; at BLINK_FRAMES-1 it clears and phase toggles.
REQ-020 Command FSM state IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch chan/mode/step and go to PEND.
REQ-021 Command FSM state PEND: cmd_ready=0; at the next wrap, write the latched command and go to IDLE.
REQ-022 Command apply SHALL set mode and step and clear duty, dir, blink counter and phase to 0.
REQ-023 The per-frame update in the apply cycle SHALL NOT run on the written channel; the other channels SHALL update normally.
REQ-024 A command accepted in the same cycle cnt==PERIOD-1 SHALL apply at the following wrap, never the current one.
REQ-025 At most one command SHALL be pending; cmd_ready SHALL return high the cycle after apply.
REQ-026 The led output SHALL lag its internal decision by exactly one cycle, identically for all channels.
REQ-027 Changing one channel SHALL NOT disturb cnt or the phase of any other channel.

Reset
REQ-028 While rst_n=0: cnt=0, frame_tick=0, led=4'b0000, FSM=IDLE, cmd_ready=0.
REQ-029 While rst_n=0, every channel SHALL be mode OFF with step, duty, dir, blink counter and phase 0.
REQ-030 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-frame or in PEND SHALL discard the pending command and force the REQ-028/029 state immediately, without a clock.

Verification (PERIOD=8, BLINK_FRAMES=2)
REQ-032 Reset release, no commands -> led=0000 permanently; frame_tick pulses every 8 cycles.
REQ-033 cmd ch0 ON -> cmd_ready low until the next wrap; led[0]=1 from one cycle after the wrap.
REQ-034 cmd ch1 BREATHE step=3 -> duty per frame 0,3,6,8,5,2,0,3; high cycles per frame match.
REQ-035 cmd ch2 BLINK -> led[2] low 2 frames, high 2 frames, repeating (period 32 cycles).
REQ-036 cmd_valid on the cnt==7 cycle -> accepted; applied at the wrap 8 cycles later, not the immediate wrap.
REQ-037 rst_n low in PEND, mid-frame -> led=0000 and cnt=0 asynchronously; the command is never applied after release.

Source files
------------

// File: rtl/led_pulse_scheduler.sv
// ---------------------------------------------------------------------------
// led_pulse_scheduler
//
// Four-channel LED driver sharing one PWM frame counter.  Each channel runs
// one of four modes:
//   OFF      - LED held low
//   ON       - LED held high
//   BREATHE  - PWM duty ramps up/down by 'step' once per frame (triangle)
//   BLINK    - LED toggles every BLINK_FRAMES frames
//
// Commands arrive on a valid/ready handshake and are held in a single-entry
// pending slot.  A pending command is written into its channel at the next
// frame wrap, so a mode change always starts on a frame boundary.
//
// Parameters
//   PERIOD        frame length in clk cycles (2 .. 2^24-1)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous, active-low reset
//   cmd_valid   command present
//   cmd_ready   scheduler can accept a command (low in reset and while a
//               command is pending)
//   cmd_chan    target channel 0..3
//   cmd_mode    0 OFF, 1 ON, 2 BREATHE, 3 BLINK
//   cmd_step    breathe duty increment per frame
//   led         registered per-channel LED drive
//   frame_tick  registered, one-cycle pulse in the cnt==0 cycle after a wrap
// ---------------------------------------------------------------------------
module led_pulse_scheduler #(
  parameter int PERIOD       = 500000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_chan,
  input  logic [1:0]  cmd_mode,
  input  logic [23:0] cmd_step,
  output logic [3:0]  led,
  output logic        frame_tick
);

  // Blink counter only needs to reach BLINK_FRAMES-1.
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [23:0]   CNT_LAST    = 24'(PERIOD - 1);
  localparam logic [23:0]   PERIOD_24   = 24'(PERIOD);
  localparam logic [24:0]   PERIOD_25   = 25'(PERIOD);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Shared frame counter
  // -------------------------------------------------------------------------
  logic [23:0] cnt_reg;
  logic        frame_tick_reg;
  logic        wrap;

  // 'wrap' is the last cycle of a frame; every per-frame update and every
  // command apply happens on the edge that closes this cycle.
  assign wrap = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      cnt_reg        <= wrap ? 24'd0 : cnt_reg + 24'd1;
      frame_tick_reg <= wrap;
    end
  end

  assign frame_tick = frame_tick_reg;

  // -------------------------------------------------------------------------
  // Command FSM
  // -------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic        ready_en_reg;   // holds cmd_ready low until the first edge out of reset
  logic        accept;
  logic        apply;
  logic [1:0]  pend_chan_reg;
  mode_t       pend_mode_reg;
  logic [23:0] pend_step_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    apply      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = ready_en_reg;
        if (cmd_valid && ready_en_reg) begin
          accept     = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        // A command accepted on the wrap cycle only reaches PEND after that
        // wrap, so it naturally waits for the following one.
        if (wrap) begin
          apply      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pending command slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_chan_reg <= '0;
      pend_mode_reg <= MODE_OFF;
      pend_step_reg <= '0;
    end else if (accept) begin
      pend_chan_reg <= cmd_chan;
      pend_mode_reg <= mode_t'(cmd_mode);
      pend_step_reg <= cmd_step;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel state and LED decision
  // -------------------------------------------------------------------------
  logic [3:0] led_next;
  logic [3:0] led_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_chan
    mode_t       mode_reg;
    logic [23:0] step_reg;
    logic [23:0] duty_reg;
    logic        dir_reg;        // 0 = ramping up, 1 = ramping down
    logic [BW-1:0] blink_cnt_reg;
    logic        phase_reg;
    logic        write_sel;
    logic [24:0] duty_sum;       // one spare bit so duty+step never wraps
    logic        decision;

    assign write_sel = apply && (pend_chan_reg == 2'(gi));
    assign duty_sum  = {1'b0, duty_reg} + {1'b0, step_reg};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_reg      <= MODE_OFF;
        step_reg      <= '0;
        duty_reg      <= '0;
        dir_reg       <= 1'b0;
        blink_cnt_reg <= '0;
        phase_reg     <= 1'b0;
      end else if (write_sel) begin
        // The written channel restarts cleanly; its per-frame update is
        // skipped this cycle so the new mode begins at duty 0 / phase 0.
        mode_reg      <= pend_mode_reg;
        step_reg      <= pend_step_reg;
        duty_reg      <= '0;
        dir_reg       <= 1'b0;
        blink_cnt_reg <= '0;
        phase_reg     <= 1'b0;
      end else if (wrap) begin
        case (mode_reg)
          MODE_BREATHE: begin
            if (!dir_reg) begin
              if (duty_sum >= PERIOD_25) begin
                duty_reg <= PERIOD_24;
                dir_reg  <= 1'b1;
              end else begin
                duty_reg <= duty_sum[23:0];
              end
            end else begin
              if (duty_reg <= step_reg) begin
                duty_reg <= '0;
                dir_reg  <= 1'b0;
              end else begin
                duty_reg <= duty_reg - step_reg;
              end
            end
          end
          MODE_BLINK: begin
            if (blink_cnt_reg == BLINK_LAST) begin
              blink_cnt_reg <= '0;
              phase_reg     <= ~phase_reg;
            end else begin
              blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    always_comb begin
      decision = 1'b0;
      case (mode_reg)
        MODE_OFF:     decision = 1'b0;
        MODE_ON:      decision = 1'b1;
        MODE_BREATHE: decision = (cnt_reg < duty_reg);
        MODE_BLINK:   decision = phase_reg;
        default:      decision = 1'b0;
      endcase
    end

    assign led_next[gi] = decision;
  end

  // All channels pass through the same register, so every LED lags its
  // decision by exactly one cycle and stays glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg <= 4'b0000;
    end else begin
      led_reg <= led_next;
    end
  end

  assign led = led_reg;

endmodule

// File: tb/tb_led_pulse_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_pulse_scheduler
//
// PERIOD=8, BLINK_FRAMES=2.  The stimulus walks frame by frame through a
// directed table.  At the start of each frame it pushes the expected number
// of LED-high cycles per channel and cmd_ready-high cycles for that frame,
// then optionally issues a command at a given cnt position.  A monitor
// accumulates the observed counts over each frame window (shifted by the
// one-cycle LED lag) and pops/compares on every frame_tick.
// ---------------------------------------------------------------------------
module tb_led_pulse_scheduler;

  localparam int PERIOD       = 8;
  localparam int BLINK_FRAMES = 2;
  localparam int NFR          = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_chan;
  logic [1:0]  cmd_mode;
  logic [23:0] cmd_step;
  logic [3:0]  led;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int l0;
    int l1;
    int l2;
    int l3;
    int rdy;
  } rec_t;

  rec_t exp_q[$];

  // Hand-computed per-frame expectations for frames 1..14 after release.
  // ch0 ON (frame 3), ch1 BREATHE step 3 (frame 4), ch2 BLINK (frame 5),
  // ch3 ON accepted on cnt==7 (frame 7, applies after frame 8),
  // ch0 OFF (frame 11).
  int tab_l0  [NFR] = '{0,0,0,8,8,8,8,8,8,8,8,0,0,0};
  int tab_l1  [NFR] = '{0,0,0,0,0,3,6,8,5,2,0,3,6,8};
  int tab_l2  [NFR] = '{0,0,0,0,0,0,0,8,8,0,0,8,8,0};
  int tab_l3  [NFR] = '{0,0,0,0,0,0,0,0,8,8,8,8,8,8};
  int tab_rdy [NFR] = '{8,8,3,3,3,8,7,1,8,8,4,8,8,8};
  int cmd_at  [NFR] = '{-1,-1,2,2,2,-1,7,-1,-1,-1,3,-1,-1,-1};
  int cmd_ch  [NFR] = '{0,0,0,1,2,0,3,0,0,0,0,0,0,0};
  int cmd_md  [NFR] = '{0,0,1,2,3,0,1,0,0,0,0,0,0,0};
  int cmd_st  [NFR] = '{0,0,0,3,0,0,0,0,0,0,0,0,0,0};

  led_pulse_scheduler #(
    .PERIOD       (PERIOD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_chan   (cmd_chan),
    .cmd_mode   (cmd_mode),
    .cmd_step   (cmd_step),
    .led        (led),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next frame_tick cycle (sampled on the falling edge).
  task automatic next_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 20);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL frame_tick timeout: got no tick in %0d cycles, expected one within 8", n);
    end
  endtask

  // Release reset on a falling edge and sync to the first frame_tick.
  task automatic release_and_sync(input string tag);
    int n = 0;
    rst_n = 1'b1;
    #1;
    check({tag, " cmd_ready before first edge"}, int'(cmd_ready), 0);
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, " cmd_ready after first edge"}, int'(cmd_ready), 1);
    end while (!frame_tick && n < 20);
    check({tag, " cycles to first tick"}, n, 8);
  endtask

  // Issue one command on the cycle with cnt==c (caller is at a tick).
  task automatic issue_cmd(input int c, input int ch, input int md, input int st);
    repeat (c) @(negedge clk);
    cmd_chan  = 2'(ch);
    cmd_mode  = 2'(md);
    cmd_step  = 24'(st);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("cmd  chan=%0d mode=%0d step=%0d at cnt=%0d", ch, md, st, c);
  endtask

  task automatic push_rec(input int a, input int b, input int c, input int d, input int r);
    rec_t rec;
    rec.l0 = a; rec.l1 = b; rec.l2 = c; rec.l3 = d; rec.rdy = r;
    exp_q.push_back(rec);
  endtask

  // Monitor: a frame window is the led samples from the cycle after one
  // tick through the next tick cycle inclusive (LED lags by one cycle).
  initial begin : monitor
    int   a0, a1, a2, a3, ar, cyc, fr;
    bit   started;
    rec_t r;
    started = 0; a0 = 0; a1 = 0; a2 = 0; a3 = 0; ar = 0; cyc = 0; fr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        started = 0;
        fr = 0;
      end else begin
        if (started) begin
          cyc++;
          a0 += int'(led[0]);
          a1 += int'(led[1]);
          a2 += int'(led[2]);
          a3 += int'(led[3]);
          ar += int'(cmd_ready);
        end
        if (frame_tick) begin
          if (started) begin
            fr++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame %0d unexpected: got frame, expected none queued", fr);
            end else begin
              r = exp_q.pop_front();
              $display("frame %0d led_hi=%0d/%0d/%0d/%0d ready_hi=%0d", fr, a0, a1, a2, a3, ar);
              check($sformatf("frame %0d led[0] high cycles", fr), a0, r.l0);
              check($sformatf("frame %0d led[1] high cycles", fr), a1, r.l1);
              check($sformatf("frame %0d led[2] high cycles", fr), a2, r.l2);
              check($sformatf("frame %0d led[3] high cycles", fr), a3, r.l3);
              check($sformatf("frame %0d cmd_ready high cycles", fr), ar, r.rdy);
              check($sformatf("frame %0d tick spacing", fr), cyc, PERIOD);
            end
          end
          started = 1;
          a0 = 0; a1 = 0; a2 = 0; a3 = 0; ar = 0; cyc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_chan  = '0;
    cmd_mode  = '0;
    cmd_step  = '0;

    repeat (3) @(negedge clk);
    check("reset led", int'(led), 0);
    check("reset frame_tick", int'(frame_tick), 0);
    check("reset cmd_ready", int'(cmd_ready), 0);

    // Phase A: directed frame table
    release_and_sync("release1");
    for (int k = 0; k < NFR; k++) begin
      if (k > 0) next_frame();
      push_rec(tab_l0[k], tab_l1[k], tab_l2[k], tab_l3[k], tab_rdy[k]);
      if (cmd_at[k] >= 0) issue_cmd(cmd_at[k], cmd_ch[k], cmd_md[k], cmd_st[k]);
    end
    next_frame();
    #1;
    check("phase A queue drained", exp_q.size(), 0);

    // Phase B: reset asserted mid-frame while a command is pending
    issue_cmd(2, 1, 1, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset led", int'(led), 0);
    check("async reset frame_tick", int'(frame_tick), 0);
    check("async reset cmd_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    release_and_sync("release2");
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_frame();
      push_rec(0, 0, 0, 0, 8);
    end
    next_frame();
    #1;
    check("phase B queue drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
